// File: rtl/fact_unit_arbiter.sv
// Round-robin arbiter sharing one factorial unit between NUM_REQ requesters.
// Optional one-entry result cache enabled by defining FACT_ARB_CACHE_EN.
//
// state       | meaning
// S_IDLE      | arbitrate pending requests, pulse gnt to the winner
// S_ISSUE     | first cycle of fu_go, clear the timeout counter
// S_WAIT_BUSY | hold fu_go until the unit drops done, errors, or times out
// S_WAIT_DONE | unit busy; capture its result when done rises again
// S_RESP      | present the tagged response until rsp_ready
module fact_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int N_W     = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 8,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*N_W-1:0] req_n,
  output logic [NUM_REQ-1:0]     gnt,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_err,
  output logic                   fu_go,
  output logic [N_W-1:0]         fu_n,
  input  logic                   fu_done,
  input  logic                   fu_err,
  input  logic [DATA_W-1:0]      fu_result
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  logic [2:0]        state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   id_q;
  logic [CNT_W-1:0]  tmo_cnt;
  logic [ID_W-1:0]   win;
  logic              win_found;
  logic [N_W-1:0]    win_n;
  logic              cache_hit;
  logic [DATA_W-1:0] hit_data;
  int                scan_idx;

  // First set request bit at or above rr_ptr, wrapping around.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    scan_idx  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win       = ID_W'(scan_idx);
      end
    end
  end

  assign win_n = req_n[int'(win)*N_W +: N_W];

`ifdef FACT_ARB_CACHE_EN
  logic              cache_valid;
  logic [N_W-1:0]    cache_n;
  logic [DATA_W-1:0] cache_result;

  assign cache_hit = cache_valid && (cache_n == win_n);
  assign hit_data  = cache_result;

  // Only clean completions out of WAIT_DONE refresh the cache.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_valid  <= 1'b0;
      cache_n      <= '0;
      cache_result <= '0;
    end else if (state == S_WAIT_DONE && fu_done) begin
      cache_valid  <= 1'b1;
      cache_n      <= fu_n;
      cache_result <= fu_result;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_data  = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      tmo_cnt   <= '0;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      fu_go     <= 1'b0;
      fu_n      <= '0;
    end else begin
      gnt <= '0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            gnt    <= NUM_REQ'(1) << win;
            id_q   <= win;
            rr_ptr <= (win == ID_LAST) ? '0 : win + 1'b1;
            if (cache_hit) begin
              rsp_valid <= 1'b1;
              rsp_id    <= win;
              rsp_data  <= hit_data;
              rsp_err   <= 1'b0;
              state     <= S_RESP;
            end else begin
              fu_n  <= win_n;
              fu_go <= 1'b1;
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          tmo_cnt <= '0;
          state   <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (fu_err || (fu_done && tmo_cnt == TMO_LAST)) begin
            fu_go     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            state     <= S_RESP;
          end else if (!fu_done) begin
            fu_go <= 1'b0;
            state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (fu_done) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_data  <= fu_result;
            rsp_err   <= 1'b0;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          fu_go     <= 1'b0;
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
